alu_muldiv: RTL and testbench

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/alu_muldiv.sv | 161 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// RV32M-style multiply/divide unit: single-cycle registered multiply, XLEN-cycle
// restoring divider, with reservation-station issue and ROB result handshakes.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_from_rs,
    input  logic [2:0]       op_from_rs,
    input  logic [XLEN-1:0]  v1_from_rs,
    input  logic [XLEN-1:0]  v2_from_rs,
    input  logic [TAG_W-1:0] tag_from_rs,
    output logic             ready_to_rs,
    input  logic             clear_from_rob,
    input  logic             ready_from_rob,
    output logic             valid_to_rob,
    output logic [XLEN-1:0]  data_to_rob,
    output logic [TAG_W-1:0] tag_to_rob
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0]  ONE      = XLEN'(1);
    localparam logic [XLEN-1:0]  ALL_ONES = '1;
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(XLEN-1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;

    function automatic logic [XLEN-1:0] f_neg_if(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + ONE) : v;
    endfunction

    function automatic logic [XLEN-1:0] f_abs(input logic [XLEN-1:0] v, input logic is_signed);
        return f_neg_if(v, is_signed & v[XLEN-1]);
    endfunction

    // Issue-side decode of divide special cases
    logic            w_in_signed;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_res;

    assign w_in_signed   = ~op_from_rs[0];
    assign w_div0        = (v2_from_rs == '0);
    assign w_ovf         = w_in_signed && (v1_from_rs == MIN_NEG) && (v2_from_rs == ALL_ONES);
    assign w_special_res = w_div0 ? (op_from_rs[1] ? v1_from_rs : ALL_ONES)
                                  : (op_from_rs[1] ? '0 : v1_from_rs);

    // Full-width product; operand extension picks signed/unsigned per op
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [2*XLEN-1:0]   w_a_ext;
    logic [2*XLEN-1:0]   w_b_ext;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_mul_res;

    assign w_a_sgn   = (r_op != 2'd3);
    assign w_b_sgn   = (r_op == 2'd1);
    assign w_a_ext   = {{XLEN{r_a[XLEN-1] & w_a_sgn}}, r_a};
    assign w_b_ext   = {{XLEN{r_b[XLEN-1] & w_b_sgn}}, r_b};
    assign w_prod    = w_a_ext * w_b_ext;
    assign w_mul_res = (r_op == 2'd0) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // One restoring step: dividend shifts out of r_a while quotient bits shift in
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic [XLEN-1:0] w_div_res;

    assign w_shift   = {r_rem, r_a[XLEN-1]};
    assign w_diff    = w_shift - {1'b0, r_b};
    assign w_ge      = ~w_diff[XLEN];
    assign w_rem_nxt = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quo_nxt = {r_a[XLEN-2:0], w_ge};
    assign w_div_res = r_op[1] ? f_neg_if(w_rem_nxt, r_neg_r) : f_neg_if(w_quo_nxt, r_neg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_tag    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (clear_from_rob) begin
            r_state  <= IDLE;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_from_rs) begin
                        r_op  <= op_from_rs[1:0];
                        r_tag <= tag_from_rs;
                        if (!op_from_rs[2]) begin
                            r_a     <= v1_from_rs;
                            r_b     <= v2_from_rs;
                            r_state <= MUL;
                        end else if (w_div0 || w_ovf) begin
                            r_result <= w_special_res;
                            r_state  <= DONE;
                        end else begin
                            r_a     <= f_abs(v1_from_rs, w_in_signed);
                            r_b     <= f_abs(v2_from_rs, w_in_signed);
                            r_rem   <= '0;
                            r_cnt   <= CNT_LOAD;
                            r_neg_q <= w_in_signed & (v1_from_rs[XLEN-1] ^ v2_from_rs[XLEN-1]);
                            r_neg_r <= w_in_signed & v1_from_rs[XLEN-1];
                            r_state <= DIV;
                        end
                    end
                end
                MUL: begin
                    r_result <= w_mul_res;
                    r_state  <= DONE;
                end
                DIV: begin
                    r_a   <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    if (r_cnt == '0) begin
                        r_result <= w_div_res;
                        r_state  <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    if (ready_from_rob) begin
                        r_result <= '0;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_to_rs  = (r_state == IDLE);
    assign valid_to_rob = (r_state == DONE);
    assign data_to_rob  = valid_to_rob ? r_result : '0;
    assign tag_to_rob   = valid_to_rob ? r_tag : '0;

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized and directed bench for alu_muldiv against an arithmetic reference model.
module tb_alu_muldiv;
    logic        clk;
    logic        rst;
    logic        valid_from_rs;
    logic [2:0]  op_from_rs;
    logic [31:0] v1_from_rs;
    logic [31:0] v2_from_rs;
    logic [3:0]  tag_from_rs;
    logic        ready_to_rs;
    logic        clear_from_rob;
    logic        ready_from_rob;
    logic        valid_to_rob;
    logic [31:0] data_to_rob;
    logic [3:0]  tag_to_rob;

    int n_checks = 0;
    int n_pass   = 0;

    alu_muldiv #(.XLEN(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .valid_from_rs(valid_from_rs), .op_from_rs(op_from_rs),
        .v1_from_rs(v1_from_rs), .v2_from_rs(v2_from_rs), .tag_from_rs(tag_from_rs),
        .ready_to_rs(ready_to_rs), .clear_from_rob(clear_from_rob),
        .ready_from_rob(ready_from_rob), .valid_to_rob(valid_to_rob),
        .data_to_rob(data_to_rob), .tag_to_rob(tag_to_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        int              ia = int'(a);
        int              ib = int'(b);
        logic [63:0]     p;
        bit              ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 3'd4) return 2;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 9));
            4: return -32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, time the result, hold it for 'hold' cycles, then acknowledge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp_d, input int exp_l,
                          input int hold, input string name);
        int lat;
        bit bad;
        @(negedge clk);
        chk({name, ":ready_before_issue"}, 64'(ready_to_rs), 64'd1);
        valid_from_rs = 1'b1; op_from_rs = op; v1_from_rs = a; v2_from_rs = b; tag_from_rs = tag;
        @(negedge clk);
        valid_from_rs = 1'b0;
        lat = 1;
        bad = 1'b0;
        while (!valid_to_rob && lat < 100) begin
            if (ready_to_rs || data_to_rob != 0 || tag_to_rob != 0) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({name, ":latency"}, 64'(lat), 64'(exp_l));
        chk({name, ":data"}, 64'(data_to_rob), 64'(exp_d));
        chk({name, ":tag"}, 64'(tag_to_rob), 64'(tag));
        chk({name, ":busy_outputs"}, 64'(bad), 64'd0);
        for (int i = 0; i < hold; i++) begin
            valid_from_rs = 1'b1; op_from_rs = 3'd0; v1_from_rs = $urandom; tag_from_rs = ~tag;
            @(negedge clk);
            chk({name, ":hold"}, {27'd0, ready_to_rs, valid_to_rob, tag_to_rob, data_to_rob},
                {27'd0, 1'b0, 1'b1, tag, exp_d});
        end
        valid_from_rs = 1'b0;
        ready_from_rob = 1'b1;
        @(negedge clk);
        ready_from_rob = 1'b0;
        chk({name, ":ack_idle"}, {27'd0, ready_to_rs, valid_to_rob, tag_to_rob, data_to_rob},
            {27'd0, 1'b1, 1'b0, 4'd0, 32'd0});
    endtask

    task automatic watch_no_valid(input string name, input int n);
        bit seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (valid_to_rob) seen = 1'b1;
        end
        chk({name, ":no_valid"}, 64'(seen), 64'd0);
    endtask

    // Start a DIV, abort it after 'cyc' DIV cycles with clear (use_rst=0) or rst (use_rst=1).
    task automatic abort_div(input bit use_rst, input int cyc, input string name);
        @(negedge clk);
        valid_from_rs = 1'b1; op_from_rs = 3'd5; v1_from_rs = 32'd100; v2_from_rs = 32'd7;
        tag_from_rs = 4'd9;
        @(negedge clk);
        valid_from_rs = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        if (use_rst) rst = 1'b1; else clear_from_rob = 1'b1;
        @(negedge clk);
        rst = 1'b0; clear_from_rob = 1'b0;
        chk({name, ":idle"}, {30'd0, ready_to_rs, valid_to_rob}, {30'd0, 1'b1, 1'b0});
        watch_no_valid(name, 40);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1; valid_from_rs = 1'b0; op_from_rs = '0; v1_from_rs = '0; v2_from_rs = '0;
        tag_from_rs = '0; clear_from_rob = 1'b0; ready_from_rob = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, ready_to_rs, valid_to_rob, tag_to_rob, data_to_rob},
            {27'd0, 1'b1, 1'b0, 4'd0, 32'd0});
        rst = 1'b0;

        run_op(3'd0, 32'd7, -32'd3, 4'd5, 32'hFFFF_FFEB, 2, 0, "mul_7x-3");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE, 2, 0, "mulhu_max");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd2, 32'hFFFF_FFFF, 2, 0, "mulhsu_-1x2");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'd0, 2, 0, "mulh_-1x-1");
        run_op(3'd4, -32'd7, 32'd2, 4'd4, 32'hFFFF_FFFD, 33, 0, "div_-7/2");
        run_op(3'd6, -32'd7, 32'd2, 4'd6, 32'hFFFF_FFFF, 33, 0, "rem_-7/2");
        run_op(3'd5, 32'd100, 32'd7, 4'd7, 32'd14, 33, 0, "divu_100/7");
        run_op(3'd4, 32'd5, 32'd0, 4'd8, 32'hFFFF_FFFF, 1, 0, "div_by0");
        run_op(3'd7, 32'd5, 32'd0, 4'd9, 32'd5, 1, 0, "remu_by0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd10, 32'h8000_0000, 1, 0, "div_ovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd11, 32'd0, 1, 0, "rem_ovf");
        run_op(3'd5, 32'd1000, 32'd3, 4'd12, 32'd333, 33, 10, "hold10");

        abort_div(1'b0, 10, "clear_mid_div");
        abort_div(1'b1, 10, "rst_mid_div");

        @(negedge clk);
        valid_from_rs = 1'b1; op_from_rs = 3'd0; v1_from_rs = 32'd3; v2_from_rs = 32'd4;
        tag_from_rs = 4'd13; clear_from_rob = 1'b1;
        @(negedge clk);
        valid_from_rs = 1'b0; clear_from_rob = 1'b0;
        chk("clear_issue:dropped", 64'(ready_to_rs), 64'd1);
        watch_no_valid("clear_issue", 6);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            run_op(op, a, b, 4'($urandom), model(op, a, b), exp_lat(op, a, b),
                   $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
